// File: rtl/i4001_rom_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// i4001_rom_arbiter_pkg
//   Shared definitions for the MCS-4 ROM store arbiter and its round-robin
//   helper.
//   - ROM_ADDR_W / ROM_DATA_W : ROM address ({chip[3:0], byte[7:0]}) and word
//                               widths.
//   - ROM_NUM_PORTS           : default number of i4001 read requesters.
//   - issue_e                 : what the arbiter puts on the BRAM port in a
//                               given cycle.
//   - rr_wrap_inc()           : modulo-n increment used to move the
//                               round-robin pointer past the last winner.
// ---------------------------------------------------------------------------
package i4001_rom_arbiter_pkg;

  localparam int ROM_ADDR_W    = 12;
  localparam int ROM_DATA_W    = 8;
  localparam int ROM_NUM_PORTS = 4;

  typedef enum logic [1:0] {
    ISSUE_IDLE  = 2'd0,
    ISSUE_WRITE = 2'd1,
    ISSUE_READ  = 2'd2
  } issue_e;

  function automatic int rr_wrap_inc(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/mcs4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mcs4_rr_arbiter
//   Purely combinational round-robin arbiter. Searches the request vector
//   starting at the pointer position and wrapping around; the first asserted
//   request wins. Shared between the ROM and RAM arbiters.
// Ports:
//   req    in   N       request vector
//   ptr    in   IDX_W   highest-priority position for this cycle
//   grant  out  N       one-hot grant (all zero when no request)
//   idx    out  IDX_W   index of the granted request (0 when none)
//   any    out  1       at least one request is asserted
// ---------------------------------------------------------------------------
module mcs4_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      // Candidate position i steps after the pointer, wrapped into 0..N-1.
      cand     = (int'(ptr) + i) % N;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/i4001_rom_arbiter.sv
// ---------------------------------------------------------------------------
// i4001_rom_arbiter
//   Shares one synchronous single-port BRAM (the ROM store) among NUM_PORTS
//   i4001 fetch requesters plus a write-only loader. The loader always wins;
//   reads are served round-robin, one issue per cycle, one cycle BRAM
//   latency, fully pipelined.
// Ports:
//   sysclk     in   1                  clock, rising edge
//   poc_n      in   1                  asynchronous active-low reset
//   rd_req     in   NUM_PORTS          per-port 1-cycle request pulse
//   rd_addr    in   NUM_PORTS*ADDR_W   per-port address, sampled with rd_req
//   rd_valid   out  NUM_PORTS          1-cycle pulse: rd_data slice updated
//   rd_data    out  NUM_PORTS*DATA_W   per-port read data, held afterwards
//   rd_busy    out  NUM_PORTS          request pending or in flight
//   ld_req     in   1                  loader write request (level)
//   ld_addr    in   ADDR_W             loader write address
//   ld_data    in   DATA_W             loader write data
//   ld_ack     out  1                  write registered onto the BRAM port
//   bram_en    out  1                  BRAM enable (registered)
//   bram_we    out  1                  BRAM write enable (registered)
//   bram_addr  out  ADDR_W             BRAM address (registered)
//   bram_din   out  DATA_W             BRAM write data (registered)
//   bram_dout  in   DATA_W             BRAM read data, 1 cycle after bram_en
// ---------------------------------------------------------------------------
module i4001_rom_arbiter
  import i4001_rom_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = ROM_NUM_PORTS,
  parameter int ADDR_W    = ROM_ADDR_W,
  parameter int DATA_W    = ROM_DATA_W
) (
  input  logic                        sysclk,
  input  logic                        poc_n,
  input  logic [NUM_PORTS-1:0]        rd_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]        rd_valid,
  output logic [NUM_PORTS*DATA_W-1:0] rd_data,
  output logic [NUM_PORTS-1:0]        rd_busy,
  input  logic                        ld_req,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        ld_ack,
  output logic                        bram_en,
  output logic                        bram_we,
  output logic [ADDR_W-1:0]           bram_addr,
  output logic [DATA_W-1:0]           bram_din,
  input  logic [DATA_W-1:0]           bram_dout
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  // Per-port request state
  logic [NUM_PORTS-1:0] pending_reg, pending_next;
  logic [NUM_PORTS-1:0] inflight_reg, inflight_next;
  logic [NUM_PORTS-1:0] valid_reg;
  logic [ADDR_W-1:0]    addr_reg [NUM_PORTS];
  logic [DATA_W-1:0]    hold_reg [NUM_PORTS];
  logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;

  // BRAM port registers
  logic                 bram_en_reg, bram_we_reg, ld_ack_reg;
  logic [ADDR_W-1:0]    bram_addr_reg;
  logic [DATA_W-1:0]    bram_din_reg;

  // Arbitration
  logic [NUM_PORTS-1:0] grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [ADDR_W-1:0]    issue_addr;
  issue_e               issue;

  mcs4_rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (PTR_W)
  ) u_rr (
    .req   (pending_reg),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // One-hot AND-OR select of the winner's latched address.
  always_comb begin
    issue_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        issue_addr = issue_addr | addr_reg[i];
      end
    end
  end

  always_comb begin
    issue         = ISSUE_IDLE;
    pending_next  = pending_reg;
    inflight_next = '0;
    rr_ptr_next   = rr_ptr_reg;
    if (ld_req) begin
      // Loader stalls all reads; pending requests simply wait.
      issue = ISSUE_WRITE;
    end else if (grant_any) begin
      issue         = ISSUE_READ;
      pending_next  = pending_reg & ~grant;
      inflight_next = grant;
      rr_ptr_next   = PTR_W'(rr_wrap_inc(int'(grant_idx), NUM_PORTS));
    end
    // A new pulse is applied after the issue clear, so a pulse arriving while
    // the port's previous request is being issued or completing becomes a
    // fresh pending request instead of being lost.
    pending_next = pending_next | rd_req;
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      pending_reg  <= '0;
      inflight_reg <= '0;
      valid_reg    <= '0;
      rr_ptr_reg   <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        addr_reg[i] <= '0;
        hold_reg[i] <= '0;
      end
    end else begin
      pending_reg  <= pending_next;
      inflight_reg <= inflight_next;
      // The read issued last cycle has its data on bram_dout now.
      valid_reg    <= inflight_reg;
      rr_ptr_reg   <= rr_ptr_next;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (rd_req[i]) begin
          addr_reg[i] <= rd_addr[i*ADDR_W +: ADDR_W];
        end
        if (valid_reg[i]) begin
          hold_reg[i] <= bram_dout;
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      bram_en_reg   <= 1'b0;
      bram_we_reg   <= 1'b0;
      bram_addr_reg <= '0;
      bram_din_reg  <= '0;
      ld_ack_reg    <= 1'b0;
    end else begin
      ld_ack_reg <= (issue == ISSUE_WRITE);
      case (issue)
        ISSUE_WRITE: begin
          bram_en_reg   <= 1'b1;
          bram_we_reg   <= 1'b1;
          bram_addr_reg <= ld_addr;
          bram_din_reg  <= ld_data;
        end
        ISSUE_READ: begin
          bram_en_reg   <= 1'b1;
          bram_we_reg   <= 1'b0;
          bram_addr_reg <= issue_addr;
        end
        default: begin
          bram_en_reg <= 1'b0;
          bram_we_reg <= 1'b0;
        end
      endcase
    end
  end

  // During the completion cycle the slice shows the BRAM output directly;
  // afterwards the captured copy holds it until the next completion.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign rd_data[gi*DATA_W +: DATA_W] = valid_reg[gi] ? bram_dout : hold_reg[gi];
    end
  endgenerate

  assign rd_valid  = valid_reg;
  assign rd_busy   = pending_reg | inflight_reg;
  assign ld_ack    = ld_ack_reg;
  assign bram_en   = bram_en_reg;
  assign bram_we   = bram_we_reg;
  assign bram_addr = bram_addr_reg;
  assign bram_din  = bram_din_reg;

endmodule
